// File: rtl/freq_div_pkg.sv
// freq_div_pkg: shared state encoding, limits and pending-request type for the clock-divider family
package freq_div_pkg;
    localparam int DIV_W = 8;
    localparam int MIN_DIV = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_e;
    typedef struct packed {
        logic en;
        logic [DIV_W-1:0] div;
    } pend_t;
endpackage

// File: rtl/freq_div_core.sv
// freq_div_core: period counter and posedge/negedge phase generation for a 50%-duty divided clock
module freq_div_core
    import freq_div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         load,
    input  logic [W-1:0] div,
    output logic         clk_out,
    output logic         tick
);
    logic [W-1:0] cnt_q, cnt_d;
    logic pos_ph, neg_ph_q, neg_ph_d;
    always_comb begin
        tick = run & (cnt_q == div - 1'b1);
        pos_ph = run & (cnt_q < (div >> 1));
        cnt_d = (!run | load | tick) ? '0 : cnt_q + 1'b1;
        neg_ph_d = rst ? 1'b0 : pos_ph;
        // odd ratios stretch the high phase by half a source cycle
        clk_out = pos_ph | (div[0] & neg_ph_q);
    end
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    always_ff @(negedge clk) neg_ph_q <= neg_ph_d;
endmodule

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: valid/ready configured divider that applies ratio changes only at output-period boundaries
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic         cfg_en,
    input  logic [W-1:0] cfg_div,
    output logic         clk_out,
    output logic         tick,
    output logic         busy,
    output logic [W-1:0] cur_div,
    output logic         err
);
    state_e state_q, state_d;
    logic [W-1:0] cur_div_q, cur_div_d;
    pend_t pend_q, pend_d;
    logic err_q, err_d, accept, illegal, load;
    always_comb begin
        cfg_ready = state_q != PEND;
        accept = cfg_valid & cfg_ready;
        illegal = cfg_en & (cfg_div < W'(MIN_DIV));
        err_d = accept & illegal;
        state_d = state_q;
        cur_div_d = cur_div_q;
        pend_d = pend_q;
        load = 1'b0;
        case (state_q)
            IDLE: if (accept & cfg_en & !illegal) begin
                state_d = RUN;
                cur_div_d = cfg_div;
                load = 1'b1;
            end
            RUN: if (accept & !illegal) begin
                state_d = PEND;
                pend_d.en = cfg_en;
                pend_d.div = DIV_W'(cfg_div);
            end
            PEND: if (tick) begin
                state_d = pend_q.en ? RUN : IDLE;
                cur_div_d = pend_q.en ? W'(pend_q.div) : '0;
                load = pend_q.en;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        state_q <= rst ? IDLE : state_d;
        cur_div_q <= rst ? '0 : cur_div_d;
        pend_q <= rst ? '0 : pend_d;
        err_q <= rst ? 1'b0 : err_d;
    end
    assign busy = state_q == PEND;
    assign cur_div = cur_div_q;
    assign err = err_q;
    freq_div_core #(.W(W)) u_core (
        .clk(clk),
        .rst(rst),
        .run(state_q != IDLE),
        .load(load),
        .div(cur_div_q),
        .clk_out(clk_out),
        .tick(tick)
    );
endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb_freq_div_ctrl: directed checks of handshake, boundary-aligned ratio changes and odd/even duty
module tb_freq_div_ctrl;
    logic clk, rst, cfg_valid, cfg_ready, cfg_en, clk_out, tick, busy, err;
    logic [7:0] cfg_div, cur_div;
    int n_tests = 0;
    int n_fail = 0;
    freq_div_ctrl #(.W(8)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_en(cfg_en), .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick),
        .busy(busy), .cur_div(cur_div), .err(err)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic req(input logic en, input logic [7:0] div);
        cfg_valid = 1'b1;
        cfg_en = en;
        cfg_div = div;
        cyc();
        cfg_valid = 1'b0;
    endtask
    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_en = 1'b0; cfg_div = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_cur_div", cur_div, 0); chk("rst_clk_out", clk_out, 0); chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0); chk("rst_err", err, 0); chk("rst_ready", cfg_ready, 1);
        req(1'b1, 8'd4);
        chk("d4_cur_div", cur_div, 4);
        for (int k = 0; k < 8; k++) begin
            chk("d4_clk_out", clk_out, (k % 4) < 2);
            chk("d4_tick", tick, (k % 4) == 3);
            chk("d4_ready", cfg_ready, 1);
            cyc();
        end
        req(1'b1, 8'd1);
        chk("ill1_err", err, 1); chk("ill1_cur_div", cur_div, 4);
        chk("ill1_clk_out", clk_out, 1); chk("ill1_busy", busy, 0);
        req(1'b1, 8'd0);
        chk("ill0_err", err, 1); chk("ill0_clk_out", clk_out, 0); chk("ill0_cur_div", cur_div, 4);
        cyc();
        chk("ill_err_clr", err, 0); chk("ill_tick", tick, 1); chk("ill_clk_out", clk_out, 0);
        cyc(); cyc();
        req(1'b1, 8'd6);
        chk("p6_busy", busy, 1); chk("p6_ready", cfg_ready, 0);
        chk("p6_cur_div_old", cur_div, 4); chk("p6_clk_out", clk_out, 0);
        cyc();
        chk("p6_busy_term", busy, 1); chk("p6_ready_term", cfg_ready, 0);
        chk("p6_tick_term", tick, 1); chk("p6_clk_term", clk_out, 0);
        cyc();
        chk("d6_cur_div", cur_div, 6); chk("d6_busy", busy, 0); chk("d6_ready", cfg_ready, 1);
        for (int k = 0; k < 12; k++) begin
            chk("d6_clk_out", clk_out, (k % 6) < 3);
            chk("d6_tick", tick, (k % 6) == 5);
            cyc();
        end
        req(1'b1, 8'd3);
        repeat (4) cyc();
        chk("p3_tick", tick, 1); chk("p3_cur_div_old", cur_div, 6);
        cyc();
        chk("d3_cur_div", cur_div, 3);
        for (int k = 0; k < 6; k++) begin
            chk("d3_clk_hi_half", clk_out, (k % 3) < 2);
            @(negedge clk); #1;
            chk("d3_clk_lo_half", clk_out, (k % 3) == 0);
            cyc();
        end
        req(1'b0, 8'd0);
        chk("stop_busy", busy, 1); chk("stop_ready", cfg_ready, 0);
        cfg_valid = 1'b1; cfg_en = 1'b1; cfg_div = 8'd7;
        cyc();
        chk("stall_ready", cfg_ready, 0); chk("stall_tick", tick, 1);
        chk("stall_busy", busy, 1); chk("stall_cur_div", cur_div, 3);
        cyc();
        chk("idle_cur_div", cur_div, 0); chk("idle_clk_out", clk_out, 0);
        chk("idle_busy", busy, 0); chk("idle_ready", cfg_ready, 1);
        cyc();
        cfg_valid = 1'b0;
        chk("d7_cur_div", cur_div, 7); chk("d7_clk_out", clk_out, 1);
        req(1'b1, 8'd9);
        chk("p9_busy", busy, 1); chk("p9_clk_out", clk_out, 1);
        rst = 1'b1;
        cyc();
        chk("prst_clk_out", clk_out, 0); chk("prst_cur_div", cur_div, 0);
        chk("prst_busy", busy, 0); chk("prst_ready", cfg_ready, 1);
        @(negedge clk); #1;
        chk("prst_clk_half", clk_out, 0);
        rst = 1'b0;
        repeat (12) cyc();
        chk("post_rst_cur_div", cur_div, 0); chk("post_rst_clk_out", clk_out, 0);
        chk("post_rst_tick", tick, 0);
        req(1'b1, 8'd5);
        chk("d5_cur_div", cur_div, 5);
        for (int k = 0; k < 10; k++) begin
            chk("d5_clk_hi_half", clk_out, (k % 5) < 3);
            chk("d5_tick", tick, (k % 5) == 4);
            @(negedge clk); #1;
            chk("d5_clk_lo_half", clk_out, (k % 5) < 2);
            cyc();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
